// File: rtl/enrutador_push.sv
// enrutador_push: single-stage routing buffer in front of a five-FIFO bank.
// Each word carries its destination FIFO in its 3 MSBs. Destinations 0..4
// are pushed to the matching FIFO when it is not full. Destinations 5..7 are
// discarded and tallied in a saturating drop counter.
module enrutador_push #(
  parameter int DATA_WIDTH = 10,
  parameter int ERR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  input  logic                  full0,
  input  logic                  full1,
  input  logic                  full2,
  input  logic                  full3,
  input  logic                  full4,
  output logic                  push0,
  output logic                  push1,
  output logic                  push2,
  output logic                  push3,
  output logic                  push4,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ERR_WIDTH-1:0]  err_cnt
);

  logic                  stage_valid_q, stage_valid_d;
  logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic [4:0] full_vec;
  logic [4:0] push_vec;
  logic [2:0] dest;
  logic [2:0] in_dest;
  logic       push_any;
  logic       accept;
  logic       in_legal;

  assign full_vec = {full4, full3, full2, full1, full0};
  assign dest     = stage_data_q[DATA_WIDTH-1:DATA_WIDTH-3];
  assign in_dest  = data_in[DATA_WIDTH-1:DATA_WIDTH-3];
  assign in_legal = (in_dest <= 3'd4);

  // Decode the staged word's destination into a one-hot push, gated by that FIFO's full flag only.
  always_comb begin
    push_vec = '0;
    for (int i = 0; i < 5; i++) begin
      push_vec[i] = stage_valid_q & (dest == 3'(i)) & ~full_vec[i];
    end
  end

  assign push_any  = |push_vec;
  assign ready_out = reset_L & (~stage_valid_q | push_any);
  assign accept    = valid_in & ready_out;

  assign push0    = push_vec[0];
  assign push1    = push_vec[1];
  assign push2    = push_vec[2];
  assign push3    = push_vec[3];
  assign push4    = push_vec[4];
  assign data_out = stage_data_q;
  assign err_cnt  = err_cnt_q;

  // Next-state: drain on push, reload on a legal accept (same edge allowed), count illegal drops.
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_data_d  = stage_data_q;
    err_cnt_d     = err_cnt_q;
    if (push_any) begin
      stage_valid_d = 1'b0;
    end
    if (accept) begin
      if (in_legal) begin
        stage_valid_d = 1'b1;
        stage_data_d  = data_in;
      end else if (err_cnt_q != {ERR_WIDTH{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any pending word and clears the drop count.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      err_cnt_q     <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_enrutador_push.sv
// Testbench for enrutador_push: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the routing stage.
module tb_enrutador_push;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       valid_in;
  logic [9:0] data_in;
  logic       ready_out;
  logic [4:0] full_v;
  logic       push0, push1, push2, push3, push4;
  logic [4:0] push_v;
  logic [9:0] data_out;
  logic [4:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  // reference model: words waiting for a FIFO, last legal word taken, drop tally
  logic [9:0] m_q[$];
  logic [9:0] m_last;
  int         m_err;

  always #5 clk = ~clk;

  enrutador_push #(.DATA_WIDTH(10), .ERR_WIDTH(5)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .valid_in (valid_in),
    .data_in  (data_in),
    .ready_out(ready_out),
    .full0    (full_v[0]),
    .full1    (full_v[1]),
    .full2    (full_v[2]),
    .full3    (full_v[3]),
    .full4    (full_v[4]),
    .push0    (push0),
    .push1    (push1),
    .push2    (push2),
    .push3    (push3),
    .push4    (push4),
    .data_out (data_out),
    .err_cnt  (err_cnt)
  );

  assign push_v = {push4, push3, push2, push1, push0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last = '0;
    m_err  = 0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model
  // to reflect the coming rising edge, then land just after that edge.
  task automatic step(input logic v, input logic [9:0] d, input logic [4:0] f, output bit acc);
    logic [4:0] exp_push;
    logic       exp_ready;
    logic [9:0] hd;
    valid_in = v;
    data_in  = d;
    full_v   = f;
    @(negedge clk);
    exp_push = '0;
    if (m_q.size() > 0) begin
      hd = m_q[0];
      if (!f[hd[9:7]]) exp_push = 5'b00001 << hd[9:7];
    end
    exp_ready = (m_q.size() == 0) || (exp_push != 0);
    chk("push", {27'd0, push_v}, {27'd0, exp_push});
    chk("ready", {31'd0, ready_out}, {31'd0, exp_ready});
    chk("data_out", {22'd0, data_out}, {22'd0, m_last});
    chk("err_cnt", {27'd0, err_cnt}, m_err);
    acc = v && exp_ready;
    if (exp_push != 0) void'(m_q.pop_front());
    if (acc) begin
      if (d[9:7] <= 3'd4) begin
        m_q.push_back(d);
        m_last = d;
      end else if (m_err < 31) begin
        m_err++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit         acc;
    logic [9:0] w;
    logic [4:0] f;
    logic       v;
    bit         pend;

    // reset held with valid_in asserted: nothing taken, everything quiet
    reset_L  = 1'b0;
    valid_in = 1'b1;
    data_in  = 10'b010_0000101;
    full_v   = '0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("rst_push", {27'd0, push_v}, 0);
      chk("rst_ready", {31'd0, ready_out}, 0);
      chk("rst_err", {27'd0, err_cnt}, 0);
      chk("rst_data", {22'd0, data_out}, 0);
    end
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    #1;
    chk("rel_ready", {31'd0, ready_out}, 1);

    // single route to FIFO 2
    step(1'b1, 10'b010_0000101, 5'b0, acc);
    step(1'b0, 10'h000, 5'b0, acc);
    chk("single_push2", {27'd0, push_v}, 0);
    @(negedge clk);
    chk("single_data", {22'd0, data_out}, 10'h105);
    @(posedge clk);
    #1;

    // streaming dest 0..4 back to back
    for (int i = 0; i < 5; i++) step(1'b1, {3'(i), 7'(8'h10 + i)}, 5'b0, acc);
    step(1'b0, 10'h000, 5'b0, acc);
    step(1'b0, 10'h000, 5'b0, acc);

    // head-of-line blocking on FIFO 3
    step(1'b1, {3'd3, 7'h33}, 5'b01000, acc);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {3'd0, 7'h44}, 5'b01000, acc);
      chk("bp_not_taken", {31'd0, acc}, 0);
    end
    step(1'b1, {3'd0, 7'h44}, 5'b00000, acc);
    chk("bp_taken", {31'd0, acc}, 1);
    step(1'b0, 10'h000, 5'b0, acc);
    step(1'b0, 10'h000, 5'b0, acc);

    // illegal destinations saturate the drop counter; legal words still flow
    for (int i = 0; i < 33; i++) begin
      step(1'b1, {3'd7, 7'($urandom)}, 5'b0, acc);
      if (i % 8 == 3) step(1'b1, {3'($urandom_range(0, 4)), 7'($urandom)}, 5'b0, acc);
    end
    step(1'b1, {3'd5, 7'h01}, 5'b0, acc);
    step(1'b1, {3'd6, 7'h02}, 5'b0, acc);
    step(1'b0, 10'h000, 5'b0, acc);
    chk("err_sat", {27'd0, err_cnt}, 31);

    // async reset while a dest-1 word is blocked
    step(1'b1, {3'd1, 7'h2A}, 5'b00010, acc);
    step(1'b0, 10'h000, 5'b00010, acc);
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst_err", {27'd0, err_cnt}, 0);
    chk("arst_push", {27'd0, push_v}, 0);
    chk("arst_ready", {31'd0, ready_out}, 0);
    chk("arst_data", {22'd0, data_out}, 0);
    model_reset();
    #1;
    reset_L = 1'b1;
    #1;
    chk("arst_rel_ready", {31'd0, ready_out}, 1);
    @(posedge clk);
    #1;
    step(1'b0, 10'h000, 5'b00000, acc);
    step(1'b0, 10'h000, 5'b00000, acc);

    // random traffic, source holds its word until accepted
    pend = 1'b0;
    w    = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 9) < 7);
        w = {3'($urandom_range(0, 7)), 7'($urandom)};
      end else begin
        v = 1'b1;
      end
      for (int j = 0; j < 5; j++) f[j] = ($urandom_range(0, 3) == 0);
      step(v, w, f, acc);
      pend = v && !acc;
    end
    step(1'b0, 10'h000, 5'b0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enrutador_push.md
Name: enrutador_push

Overview:
Upstream routing stage for the five-FIFO bank whose pushes the contador block counts. It accepts one word per cycle from the source under a valid/ready handshake and decodes a 3-bit destination field. It buffers the word in a single stage register and drives exactly one of push0..push4, with data_out, when the target FIFO is not full. Words with an illegal destination are discarded and counted.

Parameters:
DATA_WIDTH, 10, total word width; destination is data_in[DATA_WIDTH-1:DATA_WIDTH-3], payload is the remaining LSBs
ERR_WIDTH, 5, width of the saturating drop counter

Ports:
clk  input  1  system clock, rising edge
reset_L  input  1  asynchronous active-low reset
valid_in  input  1  source presents a word
data_in  input  DATA_WIDTH  word: dest in the 3 MSBs, payload below
ready_out  output  1  block accepts data_in this cycle
full0..full4  input  1 each  FIFO N full flag
push0..push4  output  1 each  write strobe to FIFO N
data_out  output  DATA_WIDTH  word presented to the FIFOs, full word unchanged
err_cnt  output  ERR_WIDTH  count of dropped words (dest 5..7)

Behaviour:
- Single clock, one clock domain. reset_L is asynchronous assert, synchronous deassert by the system.
- State:
  - stage_valid (1 bit)
  - stage_data (DATA_WIDTH bits)
  - err_cnt register
- Reset (reset_L=0), immediate and independent of clk:
  - stage_valid=0, stage_data=0, err_cnt=0.
  - push0..push4=0, data_out=0, ready_out=0 while reset_L is low.
- dest = stage_data[DATA_WIDTH-1:DATA_WIDTH-3].
- pushN is combinational: pushN = stage_valid & (dest==N) & ~fullN. At most one push is high per cycle.
- push_any = OR of push0..push4, meaning the stage drains this cycle.
- data_out = stage_data at all times. It holds its value after drain and is not cleared.
- ready_out = reset_L & (~stage_valid | push_any). This is a combinational path from fullN to ready_out.
- Accept: accept = valid_in & ready_out. On a clock edge with accept:
  - in_dest = data_in[DATA_WIDTH-1:DATA_WIDTH-3].
  - in_dest 0..4: stage_data<=data_in, stage_valid<=1.
  - in_dest 5..7: stage unchanged except stage_valid<=0 if push_any this cycle. err_cnt<=err_cnt+1, saturating at 2^ERR_WIDTH-1 (31); it never wraps.
- No accept and push_any: stage_valid<=0.
- No accept and no push_any: stage holds. A blocked word waits indefinitely for fullN to drop; there is no timeout and no reordering.
- Simultaneous drain and accept (stage full, push_any=1, valid_in=1):
  - New word loads the same edge, giving back-to-back throughput of 1 word/cycle.
- Latency: a word accepted at edge k produces pushN in the cycle following edge k, provided fullN=0.
- Backpressure: with stage_valid=1 and the target full, ready_out=0. Other FIFOs' full flags are ignored (head-of-line blocking by design).
- A valid_in=1 presented while ready_out=0 is not consumed. The source must hold data_in stable until accepted.
- Reset mid-operation: a pending stage word is lost and no push is generated. err_cnt clears.
- Full flags change only via FIFO push/pop. pushN never asserts while fullN=1.

Test Plan:
- Reset: reset_L=0 for 2 cycles with valid_in=1 -> all push=0, ready_out=0, err_cnt=0. Release -> ready_out=1 the same cycle.
- Single route: data_in=10'b010_0000101 (dest 2), valid_in=1 for one cycle, all full=0 -> push2=1 for exactly one cycle at k+1 with data_out=10'h105. Other pushes stay 0. ready_out stays 1.
- Streaming: dest 0,1,2,3,4 on consecutive cycles -> push0..push4 one-hot on consecutive cycles, no bubbles, payloads in order.
- Backpressure: full3=1, send dest 3 then dest 0 -> ready_out=0 after the first accept. push3 stays 0 and the dest-0 word is not taken. Drop full3 after 4 cycles -> push3 fires the same cycle, then the dest-0 word is accepted and push0 fires next cycle.
- Illegal destinations: 33 words with dest 7 -> no push ever asserts, err_cnt counts to 31 and holds. Interleaved legal words still route.
- Async reset mid-block: stage holds a dest-1 word with full1=1, pulse reset_L low between clock edges -> push1 never asserts, stage_valid=0, err_cnt=0 immediately.
